// File: rtl/sched_warp_stall_tracker_pkg.sv
// Shared types for the scheduler warp stall tracker: per-warp lifecycle
// states and the decode next-state encodings.
package sched_warp_stall_tracker_pkg;

   typedef enum logic [1:0] {
      READY = 2'd0,
      FETCH = 2'd1,
      BLOCK = 2'd2,
      HALT  = 2'd3
   } warp_state_t;

   localparam logic [1:0] DEC_NS_HALT = 2'b11;
   localparam logic [1:0] DEC_NS_CONT = 2'b00;

   // Encodings 01/10 are reserved; they are flagged but behave like continue.
   function automatic logic dec_ns_reserved(input logic [1:0] ns);
      return (ns != DEC_NS_HALT) && (ns != DEC_NS_CONT);
   endfunction

endpackage

// File: rtl/sched_warp_state_cell.sv
// Lifecycle state and last-decoded RVC bit for a single warp, driven by
// pre-decoded hit strobes; err flags any event illegal for the current state.
module sched_warp_state_cell
   import sched_warp_stall_tracker_pkg::*;
#(
   parameter bit IS_BOOT_WARP = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_hit,
   input  logic        dec_hit,
   input  logic        resolve_hit,
   input  logic        start_hit,
   input  logic [1:0]  dec_next_state,
   input  logic        dec_unlock,
   input  logic        dec_stall,
   input  logic        dec_rvc,
   output warp_state_t state,
   output logic        rvc,
   output logic        err
);

   warp_state_t state_d, state_q;
   logic        rvc_d, rvc_q;

   always_comb begin
      state_d = state_q;
      rvc_d   = rvc_q;
      case (state_q)
         READY: if (issue_hit) state_d = FETCH;
         FETCH: begin
            if (dec_hit) begin
               rvc_d = dec_rvc;
               if (dec_next_state == DEC_NS_HALT) state_d = HALT;
               else if (dec_unlock && !dec_stall) state_d = READY;
               else state_d = BLOCK;
            end
         end
         BLOCK: if (resolve_hit) state_d = READY;
         HALT:  if (start_hit) state_d = READY;
         default: state_d = state_q;
      endcase
   end

   // Starting an already-running warp is harmless and deliberately not an error.
   always_comb begin
      err = (issue_hit   && (state_q != READY)) ||
            (dec_hit     && (state_q != FETCH)) ||
            (resolve_hit && (state_q != BLOCK)) ||
            (dec_hit     && (dec_ns_reserved(dec_next_state) || (dec_unlock && dec_stall)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IS_BOOT_WARP ? READY : HALT;
         rvc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rvc_q   <= rvc_d;
      end
   end

   assign state = state_q;
   assign rvc   = rvc_q;

endmodule

// File: rtl/sched_warp_stall_tracker.sv
// Scheduler-side consumer of decode feedback: tracks per-warp lifecycle,
// exposes ready/stalled masks, per-warp RVC bits and a starve-cycle counter.
module sched_warp_stall_tracker
   import sched_warp_stall_tracker_pkg::*;
#(
   parameter int NUM_WARPS     = 4,
   parameter int NW_WIDTH      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   parameter int PERF_CTR_BITS = 44
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     issue_valid,
   input  logic [NW_WIDTH-1:0]      issue_wid,
   input  logic                     dec_valid,
   input  logic                     dec_unlock,
   input  logic [NW_WIDTH-1:0]      dec_wid,
   input  logic                     dec_rvc,
   input  logic                     dec_stall,
   input  logic [1:0]               dec_next_state,
   input  logic                     resolve_valid,
   input  logic [NW_WIDTH-1:0]      resolve_wid,
   input  logic                     start_valid,
   input  logic [NUM_WARPS-1:0]     start_mask,
   output logic [NUM_WARPS-1:0]     ready_warps,
   output logic [NUM_WARPS-1:0]     stalled_warps,
   output logic [NUM_WARPS-1:0]     rvc_mask,
   output logic [PERF_CTR_BITS-1:0] starve_cycles,
   output logic                     protocol_err
);

   logic [NUM_WARPS-1:0] issue_hit, dec_hit, resolve_hit, start_hit;
   logic [NUM_WARPS-1:0] cell_err, halted;
   warp_state_t          cell_state [NUM_WARPS];

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         issue_hit[w]   = issue_valid   && (issue_wid   == NW_WIDTH'(w));
         dec_hit[w]     = dec_valid     && (dec_wid     == NW_WIDTH'(w));
         resolve_hit[w] = resolve_valid && (resolve_wid == NW_WIDTH'(w));
         start_hit[w]   = start_valid   && start_mask[w];
      end
   end

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_cell
      sched_warp_state_cell #(
         .IS_BOOT_WARP (w == 0)
      ) u_cell (
         .clk            (clk),
         .reset          (reset),
         .issue_hit      (issue_hit[w]),
         .dec_hit        (dec_hit[w]),
         .resolve_hit    (resolve_hit[w]),
         .start_hit      (start_hit[w]),
         .dec_next_state (dec_next_state),
         .dec_unlock     (dec_unlock),
         .dec_stall      (dec_stall),
         .dec_rvc        (dec_rvc),
         .state          (cell_state[w]),
         .rvc            (rvc_mask[w]),
         .err            (cell_err[w])
      );
   end

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         ready_warps[w]   = (cell_state[w] == READY);
         stalled_warps[w] = (cell_state[w] == FETCH) || (cell_state[w] == BLOCK);
         halted[w]        = (cell_state[w] == HALT);
      end
   end

   logic                     protocol_err_d, protocol_err_q;
   logic [PERF_CTR_BITS-1:0] starve_d, starve_q;

   // Starved means someone could run but nobody is selectable; the counter sticks at all-ones.
   always_comb begin
      protocol_err_d = |cell_err;
      starve_d       = starve_q;
      if ((|(~halted)) && !(|ready_warps) && (starve_q != '1))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         protocol_err_q <= 1'b0;
         starve_q       <= '0;
      end else begin
         protocol_err_q <= protocol_err_d;
         starve_q       <= starve_d;
      end
   end

   assign protocol_err  = protocol_err_q;
   assign starve_cycles = starve_q;

endmodule
